// File: rtl/axis_spi_pkg.sv
// axis_spi_pkg: shared state encoding and widths for the SPI-to-AXIS receiver
package axis_spi_pkg;
  typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} state_t;
  localparam int AXIS_DATA_W = 32;
  localparam int CNT_W = $clog2(32) + 1;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep single-bit synchroniser for asynchronous SPI pins
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk) begin
    if (!resetn) r <= '0;
    else r <= {r[STAGES-2:0], d};
  end
  assign q = r[STAGES-1];
endmodule

// File: rtl/axis_spi_rx.sv
// axis_spi_rx: SPI mode-0 receiver to AXI-Stream; AXIS_SPI_RX_FIRST_EN adds m_axis_tuser first-word flag
module axis_spi_rx
  import axis_spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   SCK,
  input  logic                   MOSI,
  input  logic                   CS,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
`ifdef AXIS_SPI_RX_FIRST_EN
  output logic                   m_axis_tuser,
`endif
  output logic                   busy,
  output logic                   overrun,
  output logic                   frame_err,
  input  logic                   clear_err
);
  logic sck_s, mosi_s, cs_s, sck_d, cs_d;
  logic sck_rise, cs_rise, done, load, ov_ev, fe_ev;
  state_t state;
  logic [SPI_DATA_WIDTH-1:0] shift_reg, shift_nx;
  logic [CNT_W-1:0] bit_cnt, cnt_nx, cnt_after;
`ifdef AXIS_SPI_RX_FIRST_EN
  logic first;
`endif

  spi_sync #(.STAGES(SYNC_STAGES)) u_sck  (.clk(clk), .resetn(resetn), .d(SCK),  .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (.clk(clk), .resetn(resetn), .d(MOSI), .q(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_cs   (.clk(clk), .resetn(resetn), .d(CS),   .q(cs_s));

  always_comb begin
    sck_rise  = sck_s & ~sck_d;
    cs_rise   = cs_s & ~cs_d;
    shift_nx  = {shift_reg[SPI_DATA_WIDTH-2:0], mosi_s};
    cnt_nx    = bit_cnt + 1'b1;
    done      = (state == SHIFT) && sck_rise && (cnt_nx == CNT_W'(SPI_DATA_WIDTH));
    // a final rise coinciding with CS rise still completes the word cleanly
    cnt_after = done ? '0 : ((state == SHIFT) && sck_rise) ? cnt_nx : bit_cnt;
    load      = done && (!m_axis_tvalid || m_axis_tready);
    ov_ev     = done && !load;
    fe_ev     = (state == SHIFT) && cs_rise && (cnt_after != '0);
  end

  assign busy = (state == SHIFT) && (bit_cnt != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= RESYNC;
      sck_d         <= 1'b0;
      cs_d          <= 1'b0;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
      frame_err     <= 1'b0;
`ifdef AXIS_SPI_RX_FIRST_EN
      first         <= 1'b0;
      m_axis_tuser  <= 1'b0;
`endif
    end else begin
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      overrun   <= ov_ev | (overrun & ~clear_err);
      frame_err <= fe_ev | (frame_err & ~clear_err);
      if (load) begin
        m_axis_tdata  <= AXIS_DATA_W'(shift_nx);
        m_axis_tvalid <= 1'b1;
`ifdef AXIS_SPI_RX_FIRST_EN
        m_axis_tuser  <= first;
`endif
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        RESYNC: state <= cs_s ? IDLE : RESYNC;
        IDLE: begin
          if (!cs_s) begin
            state <= SHIFT;
`ifdef AXIS_SPI_RX_FIRST_EN
            first <= 1'b1;
`endif
          end
        end
        default: begin
          if (sck_rise) shift_reg <= shift_nx;
          bit_cnt <= cs_rise ? '0 : cnt_after;
          if (cs_rise) state <= IDLE;
`ifdef AXIS_SPI_RX_FIRST_EN
          if (done) first <= 1'b0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_spi_rx.sv
// tb_axis_spi_rx: scoreboard bench for axis_spi_rx (32-bit and 8-bit instances)
module tb_axis_spi_rx;
  logic clk = 0, resetn = 0, SCK = 0, MOSI = 0, cs32 = 1, cs8 = 1, tready = 1, clear_err = 0;
  logic [31:0] td32, td8;
  logic tv32, tv8, busy32, busy8, ov32, ov8, fe32, fe8;
  logic tu32, tu8;
  logic [32:0] q32[$], q8[$];
  logic [32:0] e32, e8;
  int cyc = 0, total = 0, bad = 0, rise_cyc = 0, beat_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_spi_rx #(.SPI_DATA_WIDTH(32), .SYNC_STAGES(2)) u32 (
    .clk(clk), .resetn(resetn), .SCK(SCK), .MOSI(MOSI), .CS(cs32),
    .m_axis_tdata(td32), .m_axis_tvalid(tv32), .m_axis_tready(tready),
`ifdef AXIS_SPI_RX_FIRST_EN
    .m_axis_tuser(tu32),
`endif
    .busy(busy32), .overrun(ov32), .frame_err(fe32), .clear_err(clear_err)
  );

  axis_spi_rx #(.SPI_DATA_WIDTH(8), .SYNC_STAGES(2)) u8 (
    .clk(clk), .resetn(resetn), .SCK(SCK), .MOSI(MOSI), .CS(cs8),
    .m_axis_tdata(td8), .m_axis_tvalid(tv8), .m_axis_tready(tready),
`ifdef AXIS_SPI_RX_FIRST_EN
    .m_axis_tuser(tu8),
`endif
    .busy(busy8), .overrun(ov8), .frame_err(fe8), .clear_err(clear_err)
  );

`ifndef AXIS_SPI_RX_FIRST_EN
  assign tu32 = 1'b0;
  assign tu8  = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && tv32 && tready) begin
      beat_cyc = cyc;
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat32_unexpected got=%h exp=none", td32);
      end else begin
        e32 = q32.pop_front();
        check("beat32", td32, e32[31:0]);
`ifdef AXIS_SPI_RX_FIRST_EN
        check("tuser32", {31'b0, tu32}, {31'b0, e32[32]});
`endif
      end
    end
    if (resetn && tv8 && tready) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat8_unexpected got=%h exp=none", td8);
      end else begin
        e8 = q8.pop_front();
        check("beat8", td8, e8[31:0]);
`ifdef AXIS_SPI_RX_FIRST_EN
        check("tuser8", {31'b0, tu8}, {31'b0, e8[32]});
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      MOSI = w[i];
      tick(4);
      SCK = 1;
      rise_cyc = cyc;
      tick(4);
      SCK = 0;
    end
  endtask

  task automatic frame32(input logic [31:0] w, input logic exp_beat);
    if (exp_beat) q32.push_back({1'b1, w});
    cs32 = 0;
    tick(4);
    spi_bits(w, 32);
    tick(4);
    cs32 = 1;
    tick(8);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && (q32.size() + q8.size()) > 0; i++) tick(1);
    check(name, 32'(q32.size() + q8.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_err = 1;
    tick(1);
    clear_err = 0;
  endtask

  initial begin
    tick(5);
    resetn = 1;
    tick(10);
    check("rst_tdata", td32, 32'h0);
    check("rst_tvalid", {31'b0, tv32}, 32'd0);
    check("rst_busy", {31'b0, busy32}, 32'd0);
    check("rst_overrun", {31'b0, ov32}, 32'd0);
    check("rst_frame_err", {31'b0, fe32}, 32'd0);

    frame32(32'hA5C3_0F96, 1'b1);
    wait_empty("drain_single");
    check("latency_ok", {31'b0, (beat_cyc - rise_cyc) <= 4}, 32'd1);
    check("single_overrun", {31'b0, ov32}, 32'd0);
    check("single_frame_err", {31'b0, fe32}, 32'd0);
    check("single_busy", {31'b0, busy32}, 32'd0);

    q8.push_back({1'b1, 32'h12});
    q8.push_back({1'b0, 32'h34});
    q8.push_back({1'b0, 32'h56});
    cs8 = 0;
    tick(4);
    spi_bits(32'h0012_3456, 24);
    tick(4);
    cs8 = 1;
    tick(8);
    wait_empty("drain_w8");
    check("w8_frame_err", {31'b0, fe8}, 32'd0);
    check("w8_overrun", {31'b0, ov8}, 32'd0);

    tready = 0;
    frame32(32'h1111_1111, 1'b1);
    frame32(32'h2222_2222, 1'b0);
    check("bp_tvalid", {31'b0, tv32}, 32'd1);
    check("bp_tdata", td32, 32'h1111_1111);
    check("bp_overrun", {31'b0, ov32}, 32'd1);
    tready = 1;
    wait_empty("drain_bp");
    tick(2);
    check("bp_overrun_sticky", {31'b0, ov32}, 32'd1);
    pulse_clear();
    check("bp_overrun_clear", {31'b0, ov32}, 32'd0);

    cs32 = 0;
    tick(4);
    spi_bits(32'h0000_1ABC, 13);
    check("fe_busy_mid", {31'b0, busy32}, 32'd1);
    tick(4);
    cs32 = 1;
    tick(8);
    check("fe_frame_err", {31'b0, fe32}, 32'd1);
    check("fe_busy_after", {31'b0, busy32}, 32'd0);
    check("fe_no_beat", {31'b0, tv32}, 32'd0);
    pulse_clear();
    check("fe_clear", {31'b0, fe32}, 32'd0);
    frame32(32'hDEAD_BEEF, 1'b1);
    wait_empty("drain_fe");

    cs32 = 0;
    tick(4);
    spi_bits(32'h0000_02AA, 10);
    resetn = 0;
    tick(3);
    resetn = 1;
    tick(4);
    spi_bits(32'h0015_5555, 22);
    tick(4);
    cs32 = 1;
    tick(8);
    check("rsm_no_beat", {31'b0, tv32}, 32'd0);
    check("rsm_frame_err", {31'b0, fe32}, 32'd0);
    frame32(32'hCAFE_F00D, 1'b1);
    wait_empty("drain_rsm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
